// File: rtl/lfsr_prbs_gen_chk.sv
// PRBS generator/checker built on a Fibonacci XNOR LFSR with a tap-mask polynomial.
// Define LFSR_ERR_INJECT_EN to add the i_Inject port, which flips the LSB of a generated word.
module lfsr_prbs_gen_chk #(
  parameter int unsigned         NUM_BITS   = 16,
  parameter logic [NUM_BITS-1:0] TAPS       = 16'hD008,
  parameter int unsigned         DATA_W     = 8,
  parameter int unsigned         LOCK_CNT   = 16,
  parameter int unsigned         UNLOCK_CNT = 4,
  parameter int unsigned         ERR_CNT_W  = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic                 i_Mode,
  input  logic                 i_Seed_DV,
  input  logic [NUM_BITS-1:0]  i_Seed_Data,
  output logic [DATA_W-1:0]    o_Data,
  output logic                 o_Data_DV,
  input  logic                 i_Chk_DV,
  input  logic [DATA_W-1:0]    i_Chk_Data,
  output logic                 o_Locked,
  output logic                 o_Err,
  output logic [ERR_CNT_W-1:0] o_Err_Count,
  input  logic                 i_Err_Clr,
`ifdef LFSR_ERR_INJECT_EN
  input  logic                 i_Inject,
`endif
  output logic                 o_Wrap
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SW = NUM_BITS + 1;
  localparam int unsigned EW = ERR_CNT_W + 6;
  localparam logic [SW-1:0] PERIOD  = {1'b0, {NUM_BITS{1'b1}}};
  localparam logic [EW-1:0] ERR_MAX = EW'({ERR_CNT_W{1'b1}});

  typedef enum logic {HUNT, LOCKED} chk_state_t;

  chk_state_t             fsm_q, fsm_d;
  logic [NUM_BITS-1:0]    lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0]    step_q, step_d;
  logic [GW-1:0]          good_q, good_d;
  logic [BW-1:0]          bad_q, bad_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d, err_base;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   data_dv_q, data_dv_d;
  logic                   err_q, err_d;
  logic                   wrap_q, wrap_d;
  logic                   mode_q;
  logic                   advance;
  logic                   inj;

  logic [NUM_BITS-1:0]    gen_state, rx_state;
  logic [DATA_W-1:0]      exp_word, rx_sh, mism, mism_sh;
  logic                   fb;
  logic [5:0]             pop;
  logic [SW-1:0]          step_sum;
  logic [EW-1:0]          err_sum;

`ifdef LFSR_ERR_INJECT_EN
  assign inj = i_Inject;
`else
  assign inj = 1'b0;
`endif

  // Run DATA_W steps ahead: free-running prediction and received-bit resync in parallel.
  always_comb begin
    gen_state = lfsr_q;
    rx_state  = lfsr_q;
    exp_word  = '0;
    rx_sh     = i_Chk_Data;
    fb        = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb        = ~^(gen_state & TAPS);
      exp_word  = (exp_word << 1) | DATA_W'(fb);
      gen_state = {gen_state[NUM_BITS-2:0], fb};
      rx_state  = {rx_state[NUM_BITS-2:0], rx_sh[DATA_W-1]};
      rx_sh     = rx_sh << 1;
    end
  end

  always_comb begin
    mism    = i_Chk_Data ^ exp_word;
    mism_sh = mism;
    pop     = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      pop     = pop + 6'(mism_sh[0]);
      mism_sh = mism_sh >> 1;
    end
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    step_d    = step_q;
    fsm_d     = fsm_q;
    good_d    = good_q;
    bad_d     = bad_q;
    data_d    = data_q;
    data_dv_d = 1'b0;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    advance   = 1'b0;
    err_base  = i_Err_Clr ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    err_sum   = EW'(err_base) + EW'(pop);
    step_sum  = {1'b0, step_q} + SW'(DATA_W);

    if (i_Seed_DV) begin
      lfsr_d = (&i_Seed_Data) ? '0 : i_Seed_Data;
      step_d = '0;
      fsm_d  = HUNT;
      good_d = '0;
      bad_d  = '0;
    end else if (i_Mode != mode_q) begin
      fsm_d  = HUNT;
      step_d = '0;
      good_d = '0;
      bad_d  = '0;
    end else if (!i_Mode) begin
      if (i_Enable) begin
        advance   = 1'b1;
        lfsr_d    = gen_state;
        data_d    = exp_word;
        data_d[0] = exp_word[0] ^ inj;
        data_dv_d = 1'b1;
      end
    end else if (i_Chk_DV) begin
      advance = 1'b1;
      if (fsm_q == HUNT) begin
        lfsr_d = rx_state;
        if (mism == '0) begin
          if (good_q == GW'(LOCK_CNT - 1)) begin
            fsm_d  = LOCKED;
            good_d = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else begin
          good_d = '0;
        end
      end else begin
        lfsr_d = gen_state;
        if (mism != '0) begin
          err_d     = 1'b1;
          err_cnt_d = (err_sum > ERR_MAX) ? '1 : ERR_CNT_W'(err_sum);
          if (bad_q == BW'(UNLOCK_CNT - 1)) begin
            fsm_d  = HUNT;
            good_d = '0;
            bad_d  = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end else begin
          bad_d = '0;
        end
      end
    end

    if (advance) begin
      if (step_sum >= PERIOD) begin
        step_d = NUM_BITS'(step_sum - PERIOD);
        wrap_d = 1'b1;
      end else begin
        step_d = NUM_BITS'(step_sum);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      lfsr_q    <= '0;
      step_q    <= '0;
      fsm_q     <= HUNT;
      good_q    <= '0;
      bad_q     <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      data_dv_q <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      mode_q    <= i_Mode;
    end else begin
      lfsr_q    <= lfsr_d;
      step_q    <= step_d;
      fsm_q     <= fsm_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      data_dv_q <= data_dv_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      mode_q    <= i_Mode;
    end
  end

  assign o_Data      = data_q;
  assign o_Data_DV   = data_dv_q;
  assign o_Locked    = (fsm_q == LOCKED);
  assign o_Err       = err_q;
  assign o_Err_Count = err_cnt_q;
  assign o_Wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Directed bench: 4-bit sequence table, 16-bit generator-to-checker loopback, saturation and seeding.
module tb_lfsr_prbs_gen_chk;

  logic i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic rst_n;

  logic        g_en, g_seed_dv, g_inj;
  logic [15:0] g_seed;
  logic [7:0]  g_data;
  logic        g_dv, g_wrap, g_locked, g_err;
  logic [15:0] g_errcnt;

  logic        c_mode, c_clr, c_dv;
  logic [7:0]  flip, c_data, c_odata;
  logic        c_odv, c_locked, c_err, c_wrap;
  logic [15:0] c_errcnt;

  logic        c4_clr;
  logic [7:0]  flip4, c4_data, c4_odata;
  logic        c4_odv, c4_locked, c4_err, c4_wrap;
  logic [3:0]  c4_errcnt;

  logic        s_en, s_data, s_dv, s_wrap, s_locked, s_err;
  logic [15:0] s_errcnt;

  assign c_dv    = g_dv;
  assign c_data  = g_data ^ flip;
  assign c4_data = g_data ^ flip4;

  lfsr_prbs_gen_chk u_gen (
    .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Enable(g_en), .i_Mode(1'b0),
    .i_Seed_DV(g_seed_dv), .i_Seed_Data(g_seed), .o_Data(g_data), .o_Data_DV(g_dv),
    .i_Chk_DV(1'b0), .i_Chk_Data(8'h00), .o_Locked(g_locked), .o_Err(g_err),
    .o_Err_Count(g_errcnt), .i_Err_Clr(1'b0),
`ifdef LFSR_ERR_INJECT_EN
    .i_Inject(g_inj),
`endif
    .o_Wrap(g_wrap)
  );

  lfsr_prbs_gen_chk u_chk (
    .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Enable(1'b0), .i_Mode(c_mode),
    .i_Seed_DV(1'b0), .i_Seed_Data(16'h0000), .o_Data(c_odata), .o_Data_DV(c_odv),
    .i_Chk_DV(c_dv), .i_Chk_Data(c_data), .o_Locked(c_locked), .o_Err(c_err),
    .o_Err_Count(c_errcnt), .i_Err_Clr(c_clr),
`ifdef LFSR_ERR_INJECT_EN
    .i_Inject(1'b0),
`endif
    .o_Wrap(c_wrap)
  );

  lfsr_prbs_gen_chk #(.ERR_CNT_W(4)) u_chk4 (
    .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Enable(1'b0), .i_Mode(1'b1),
    .i_Seed_DV(1'b0), .i_Seed_Data(16'h0000), .o_Data(c4_odata), .o_Data_DV(c4_odv),
    .i_Chk_DV(c_dv), .i_Chk_Data(c4_data), .o_Locked(c4_locked), .o_Err(c4_err),
    .o_Err_Count(c4_errcnt), .i_Err_Clr(c4_clr),
`ifdef LFSR_ERR_INJECT_EN
    .i_Inject(1'b0),
`endif
    .o_Wrap(c4_wrap)
  );

  lfsr_prbs_gen_chk #(.NUM_BITS(4), .TAPS(4'hC), .DATA_W(1)) u_small (
    .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Enable(s_en), .i_Mode(1'b0),
    .i_Seed_DV(1'b0), .i_Seed_Data(4'h0), .o_Data(s_data), .o_Data_DV(s_dv),
    .i_Chk_DV(1'b0), .i_Chk_Data(1'b0), .o_Locked(s_locked), .o_Err(s_err),
    .o_Err_Count(s_errcnt), .i_Err_Clr(1'b0),
`ifdef LFSR_ERR_INJECT_EN
    .i_Inject(1'b0),
`endif
    .o_Wrap(s_wrap)
  );

  typedef struct {
    logic en;
    logic data;
    logic dv;
    logic wrap;
  } vec_t;

  vec_t        tbl[31];
  logic [14:0] seq;
  logic        err_seen;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  initial begin
    rst_n = 1'b0; g_en = 1'b0; g_seed_dv = 1'b0; g_seed = '0; g_inj = 1'b0;
    c_mode = 1'b1; c_clr = 1'b0; flip = '0; c4_clr = 1'b0; flip4 = '0; s_en = 1'b0;

    // Hand-derived 4-bit XNOR sequence from state 0, taps {3,2}, first bit leftmost.
    seq = 15'b111011001010000;
    for (int unsigned i = 0; i < 15; i++)
      tbl[i] = '{en: 1'b1, data: seq[14-i], dv: 1'b1, wrap: (i == 14)};
    tbl[15] = '{en: 1'b0, data: 1'b0, dv: 1'b0, wrap: 1'b0};
    for (int unsigned i = 16; i < 31; i++)
      tbl[i] = '{en: 1'b1, data: seq[14-(i-16)], dv: 1'b1, wrap: (i == 30)};

    tick(); tick();
    check("rst_g_data", 32'(g_data), 32'h0);
    check("rst_g_dv", 32'(g_dv), 32'h0);
    check("rst_g_wrap", 32'(g_wrap), 32'h0);
    check("rst_c_locked", 32'(c_locked), 32'h0);
    check("rst_c_err", 32'(c_err), 32'h0);
    check("rst_c_errcnt", 32'(c_errcnt), 32'h0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 31; i++) begin
      s_en = tbl[i].en;
      tick();
      check($sformatf("small_row%0d {dv,wrap,data}", i), {29'h0, s_dv, s_wrap, s_data},
            {29'h0, tbl[i].dv, tbl[i].wrap, tbl[i].data});
    end
    s_en = 1'b0;

    g_en = 1'b1;
    tick();
    check("gen_word1", 32'(g_data), 32'hF0);
    for (int unsigned w = 1; w <= 16; w++) begin
      tick();
      if (w == 1)  check("gen_word2", 32'(g_data), 32'hF6);
      if (w == 15) check("lock_after15", 32'(c_locked), 32'h0);
    end
    check("lock_after16", 32'(c_locked), 32'h1);
    check("lock4_after16", 32'(c4_locked), 32'h1);

    err_seen = 1'b0;
    repeat (1000) begin
      tick();
      if (c_err) err_seen = 1'b1;
    end
    check("clean_err_seen", 32'(err_seen), 32'h0);
    check("clean_errcnt", 32'(c_errcnt), 32'h0);
    check("clean_locked", 32'(c_locked), 32'h1);

`ifdef LFSR_ERR_INJECT_EN
    g_inj = 1'b1; tick(); g_inj = 1'b0; tick();
    check("inject_errcnt", 32'(c_errcnt), 32'h1);
    check("inject_locked", 32'(c_locked), 32'h1);
`endif
    c_clr = 1'b1; c4_clr = 1'b1; tick(); c_clr = 1'b0; c4_clr = 1'b0;
    check("clr_errcnt", 32'(c_errcnt), 32'h0);
    check("clr4_errcnt", 32'(c4_errcnt), 32'h0);

    flip = 8'hA4; tick(); flip = 8'h00;
    check("flip3_err", 32'(c_err), 32'h1);
    check("flip3_errcnt", 32'(c_errcnt), 32'h3);
    check("flip3_locked", 32'(c_locked), 32'h1);
    tick();
    check("flip3_err_pulse", 32'(c_err), 32'h0);
    check("flip3_errcnt_hold", 32'(c_errcnt), 32'h3);

    flip = 8'h10;
    for (int unsigned k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) check("unlock_after3", 32'(c_locked), 32'h1);
    end
    flip = 8'h00;
    check("unlock_after4", 32'(c_locked), 32'h0);
    check("unlock_errcnt", 32'(c_errcnt), 32'h7);

    for (int unsigned k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) check("relock_after15", 32'(c_locked), 32'h0);
    end
    check("relock_after16", 32'(c_locked), 32'h1);

    for (int unsigned k = 0; k < 10; k++) begin
      flip4 = (k % 2 == 0) ? 8'hF0 : 8'h00;
      tick();
      if (k == 0) check("sat_first", 32'(c4_errcnt), 32'h4);
    end
    flip4 = 8'h00;
    check("sat_errcnt", 32'(c4_errcnt), 32'hF);
    check("sat_locked", 32'(c4_locked), 32'h1);
    flip4 = 8'h03; c4_clr = 1'b1; tick(); flip4 = 8'h00; c4_clr = 1'b0;
    check("clr_plus_err", 32'(c4_errcnt), 32'h2);

    c_mode = 1'b0; tick();
    check("mode_change_unlock", 32'(c_locked), 32'h0);
    c_mode = 1'b1; tick();

    g_seed = 16'hFFFF; g_seed_dv = 1'b1; tick(); g_seed_dv = 1'b0;
    check("seed_wins_dv", 32'(g_dv), 32'h0);
    tick();
    check("seed_ones_word1", {23'h0, g_dv, g_data}, {23'h0, 1'b1, 8'hF0});
    tick();
    check("seed_ones_word2", 32'(g_data), 32'hF6);

    rst_n = 1'b0; tick();
    check("rerst_errcnt4", 32'(c4_errcnt), 32'h0);
    check("rerst_locked4", 32'(c4_locked), 32'h0);
    check("rerst_g_dv", 32'(g_dv), 32'h0);
    check("rerst_g_data", 32'(g_data), 32'h0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
